// File: rtl/ber_sweep_ctrl_pkg.sv
// Shared definitions for the BER sweep controller: state encoding, default
// sweep parameters and the noise-select width.
package ber_sweep_ctrl_pkg;

    localparam int NOISE_W                 = 4;
    localparam int DEF_FRAMES_PER_STEP     = 64;
    localparam int DEF_NUM_STEPS           = 16;
    localparam int DEF_SETTLE_CYC          = 256;
    localparam int DEF_SYNC_TIMEOUT        = 4096;
    localparam int DEF_ERR_W               = 20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_REPORT    = 3'd4,
        ST_DONE      = 3'd5
    } sweep_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ber_sweep_ctrl_if.sv
// Control, link-status and result signals between the BER sweep controller
// and its surroundings (noise_adder select, bake_m_idfy status, logging path).
interface ber_sweep_ctrl_if #(parameter int ERR_W = 20);
    import ber_sweep_ctrl_pkg::*;

    logic               start;
    logic               abort;
    logic               sync_lock;
    logic               frame_tick;
    logic               bit_err;
    logic [NOISE_W-1:0] noise_sel;
    logic               busy;
    logic               done;
    logic               res_valid;
    logic [NOISE_W-1:0] res_step;
    logic [ERR_W-1:0]   res_err;
    logic               res_timeout;

    modport master (
        output start, abort, sync_lock, frame_tick, bit_err,
        input  noise_sel, busy, done, res_valid, res_step, res_err, res_timeout
    );

    modport slave (
        input  start, abort, sync_lock, frame_tick, bit_err,
        output noise_sel, busy, done, res_valid, res_step, res_err, res_timeout
    );

endinterface

// File: rtl/ber_sweep_ctrl_sat_counter.sv
// Saturating up-counter used as the per-step bit error accumulator.
module ber_sweep_ctrl_sat_counter #(
    parameter int WIDTH = 20
) (
    input  logic             clk_fs,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             saturated
);

    assign saturated = &q;

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !saturated) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ber_sweep_ctrl.sv
// BER sweep sequencer: steps the noise code, flushes, waits for sequence lock,
// counts bit errors over a fixed number of frames and publishes one result per step.
//
// state      | meaning
// IDLE       | waiting for start, noise_sel parked at 0
// SETTLE     | fixed hold after a noise change while the filters flush
// WAIT_SYNC  | waiting for a frame boundary with sync_lock, bounded by timeout
// MEASURE    | accumulating bit errors and frames
// REPORT     | one-cycle result strobe, then next step or DONE
// DONE       | sweep complete, waiting for start
module ber_sweep_ctrl
    import ber_sweep_ctrl_pkg::*;
#(
    parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
    parameter int NUM_STEPS       = DEF_NUM_STEPS,
    parameter int SETTLE_CYC      = DEF_SETTLE_CYC,
    parameter int SYNC_TIMEOUT    = DEF_SYNC_TIMEOUT,
    parameter int ERR_W           = DEF_ERR_W
) (
    input logic                  clk_fs,
    input logic                  rst_n,
    ber_sweep_ctrl_if.slave      bus
);

    localparam int CNT_W = (max_int(SETTLE_CYC, SYNC_TIMEOUT) > 1)
                           ? $clog2(max_int(SETTLE_CYC, SYNC_TIMEOUT)) : 1;
    localparam int FRM_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [CNT_W-1:0]   SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LD = CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [FRM_W-1:0]   FRAME_LAST = FRM_W'(FRAMES_PER_STEP - 1);
    localparam logic [NOISE_W-1:0] LAST_STEP  = NOISE_W'(NUM_STEPS - 1);

    sweep_state_t       state;
    sweep_state_t       nxt;
    logic [CNT_W-1:0]   cnt;
    logic [FRM_W-1:0]   frame_acc;
    logic [ERR_W-1:0]   err_q;
    logic               err_sat;
    logic [ERR_W-1:0]   err_d;
    logic               in_measure;

    logic [NOISE_W-1:0] noise_sel,   noise_sel_d;
    logic               busy,        busy_d;
    logic               done,        done_d;
    logic               res_valid,   res_valid_d;
    logic [NOISE_W-1:0] res_step,    res_step_d;
    logic [ERR_W-1:0]   res_err,     res_err_d;
    logic               res_timeout, res_timeout_d;

    assign in_measure = (state == ST_MEASURE);

    ber_sweep_ctrl_sat_counter #(.WIDTH(ERR_W)) u_err_acc (
        .clk_fs    (clk_fs),
        .rst_n     (rst_n),
        .inc       (in_measure && bus.bit_err),
        .clr       (!in_measure),
        .q         (err_q),
        .saturated (err_sat)
    );

    // Count as it will stand after this cycle, so the error on the final tick lands in the result.
    assign err_d = (in_measure && bus.bit_err && !err_sat) ? err_q + ERR_W'(1) : err_q;

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (bus.abort) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (bus.start) nxt = ST_SETTLE;
                ST_SETTLE:        if (cnt == '0) nxt = ST_WAIT_SYNC;
                ST_WAIT_SYNC: begin
                    if (bus.frame_tick && bus.sync_lock) nxt = ST_MEASURE;
                    else if (cnt == '0)                  nxt = ST_REPORT;
                end
                ST_MEASURE: begin
                    if (!bus.sync_lock)                                nxt = ST_WAIT_SYNC;
                    else if (bus.frame_tick && frame_acc == FRAME_LAST) nxt = ST_REPORT;
                end
                ST_REPORT:        nxt = (noise_sel == LAST_STEP) ? ST_DONE : ST_SETTLE;
                default:          nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_d        = (nxt == ST_SETTLE) || (nxt == ST_WAIT_SYNC) ||
                        (nxt == ST_MEASURE) || (nxt == ST_REPORT);
        done_d        = (nxt == ST_DONE);
        res_valid_d   = (nxt == ST_REPORT);
        res_step_d    = res_step;
        res_err_d     = res_err;
        res_timeout_d = res_timeout;
        noise_sel_d   = noise_sel;

        if (bus.abort) begin
            noise_sel_d = '0;
        end else if ((state == ST_IDLE || state == ST_DONE) && nxt == ST_SETTLE) begin
            noise_sel_d = '0;
        end else if (state == ST_REPORT && nxt == ST_SETTLE) begin
            noise_sel_d = noise_sel + NOISE_W'(1);
        end

        if (nxt == ST_REPORT) begin
            res_step_d    = noise_sel;
            res_timeout_d = (state == ST_WAIT_SYNC);
            res_err_d     = (state == ST_WAIT_SYNC) ? '1 : err_d;
        end
    end

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            noise_sel   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            res_valid   <= 1'b0;
            res_step    <= '0;
            res_err     <= '0;
            res_timeout <= 1'b0;
        end else begin
            noise_sel   <= noise_sel_d;
            busy        <= busy_d;
            done        <= done_d;
            res_valid   <= res_valid_d;
            res_step    <= res_step_d;
            res_err     <= res_err_d;
            res_timeout <= res_timeout_d;
        end
    end

    // Shared down-counter: settle hold, then lock timeout; reloaded on every entry (incl. sync loss).
    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (nxt == ST_SETTLE && state != ST_SETTLE) begin
            cnt <= SETTLE_LD;
        end else if (nxt == ST_WAIT_SYNC && state != ST_WAIT_SYNC) begin
            cnt <= TIMEOUT_LD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_fs or negedge rst_n) begin
        if (!rst_n) begin
            frame_acc <= '0;
        end else if (!in_measure) begin
            frame_acc <= '0;
        end else if (bus.frame_tick) begin
            frame_acc <= frame_acc + FRM_W'(1);
        end
    end

    assign bus.noise_sel   = noise_sel;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.res_valid   = res_valid;
    assign bus.res_step    = res_step;
    assign bus.res_err     = res_err;
    assign bus.res_timeout = res_timeout;

endmodule

// File: tb/tb_ber_sweep_ctrl.sv
// Bench for ber_sweep_ctrl: two instances (wide and 3-bit error accumulator) share
// stimulus; a queue per instance holds the expected results of each step.
module tb_ber_sweep_ctrl;
    import ber_sweep_ctrl_pkg::*;

    localparam int FPS = 4;
    localparam int NS  = 3;
    localparam int SC  = 8;
    localparam int ST  = 50;
    localparam int EW  = 20;
    localparam int EWS = 3;

    logic clk_fs = 1'b0;
    logic rst_n  = 1'b0;
    always #50 clk_fs = ~clk_fs;

    ber_sweep_ctrl_if #(.ERR_W(EW))  bus ();
    ber_sweep_ctrl_if #(.ERR_W(EWS)) bus_s ();

    assign bus_s.start      = bus.start;
    assign bus_s.abort      = bus.abort;
    assign bus_s.sync_lock  = bus.sync_lock;
    assign bus_s.frame_tick = bus.frame_tick;
    assign bus_s.bit_err    = bus.bit_err;

    ber_sweep_ctrl #(.FRAMES_PER_STEP(FPS), .NUM_STEPS(NS), .SETTLE_CYC(SC),
                     .SYNC_TIMEOUT(ST), .ERR_W(EW)) dut (
        .clk_fs (clk_fs), .rst_n (rst_n), .bus (bus));

    ber_sweep_ctrl #(.FRAMES_PER_STEP(FPS), .NUM_STEPS(NS), .SETTLE_CYC(SC),
                     .SYNC_TIMEOUT(ST), .ERR_W(EWS)) dut_sat (
        .clk_fs (clk_fs), .rst_n (rst_n), .bus (bus_s));

    typedef struct {
        int step;
        int err;
        bit to;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_s[$];
    exp_t e_m;
    exp_t e_s;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected result for one step; the error count is clipped to each accumulator width.
    task automatic push_exp(input int step, input int err, input bit to);
        exp_t a;
        exp_t b;
        int   max_m = (1 << EW) - 1;
        int   max_s = (1 << EWS) - 1;
        a.step = step; a.to = to; a.err = to ? max_m : ((err > max_m) ? max_m : err);
        b.step = step; b.to = to; b.err = to ? max_s : ((err > max_s) ? max_s : err);
        exp_q.push_back(a);
        exp_s.push_back(b);
    endtask

    always @(negedge clk_fs) begin
        if (bus.res_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_result: got step=%0d err=%0d to=%0d, none expected",
                         bus.res_step, bus.res_err, bus.res_timeout);
            end else begin
                e_m = exp_q.pop_front();
                if (bus.res_step !== 4'(e_m.step) || bus.res_err !== EW'(e_m.err) ||
                    bus.res_timeout !== e_m.to)
                    $display("FAIL result: got step=%0d err=%0d to=%0d, want step=%0d err=%0d to=%0d",
                             bus.res_step, bus.res_err, bus.res_timeout, e_m.step, e_m.err, e_m.to);
                else n_pass++;
            end
        end
        if (bus_s.res_valid === 1'b1) begin
            n_checks++;
            if (exp_s.size() == 0) begin
                $display("FAIL unexpected_result_sat: got step=%0d err=%0d, none expected",
                         bus_s.res_step, bus_s.res_err);
            end else begin
                e_s = exp_s.pop_front();
                if (bus_s.res_step !== 4'(e_s.step) || bus_s.res_err !== EWS'(e_s.err) ||
                    bus_s.res_timeout !== e_s.to)
                    $display("FAIL result_sat: got step=%0d err=%0d to=%0d, want step=%0d err=%0d to=%0d",
                             bus_s.res_step, bus_s.res_err, bus_s.res_timeout, e_s.step, e_s.err, e_s.to);
                else n_pass++;
            end
        end
    end

    task automatic cyc(input logic ft, input logic be);
        bus.frame_tick = ft;
        bus.bit_err    = be;
        @(negedge clk_fs);
        bus.frame_tick = 1'b0;
        bus.bit_err    = 1'b0;
    endtask

    task automatic idle(input int n, input logic be);
        for (int i = 0; i < n; i++) cyc(1'b0, be);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk_fs);
        bus.start = 1'b0;
    endtask

    // Lock tick, then n_frames frames of 20 cycles; errs_mid errors early in frame 0.
    task automatic step_frames(input int n_frames, input int errs_mid, input logic err_on_last,
                               input logic err_on_lock);
        bit early = 1'b0;
        cyc(1'b1, err_on_lock);
        for (int f = 0; f < n_frames; f++) begin
            for (int c = 0; c < 19; c++) begin
                cyc(1'b0, (f == 0) && (c < errs_mid));
                if (bus.res_valid === 1'b1) early = 1'b1;
            end
            if (f == n_frames - 1) begin
                cyc(1'b1, err_on_last);
                n_checks++;
                if (bus.res_valid !== 1'b1)
                    $display("FAIL report_latency: res_valid=%b after final frame_tick, want 1", bus.res_valid);
                else n_pass++;
            end else begin
                cyc(1'b1, 1'b0);
                if (bus.res_valid === 1'b1) early = 1'b1;
            end
        end
        n_checks++;
        if (early) $display("FAIL early_report: res_valid seen before frame %0d, want none", n_frames);
        else n_pass++;
    endtask

    task automatic clean_step();
        idle(12, 1'b0);
        step_frames(FPS, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_fs);
        n_checks++;
        if ({bus.noise_sel, bus.busy, bus.done, bus.res_valid, bus.res_step, bus.res_err, bus.res_timeout} !== '0)
            $display("FAIL reset_values: sel=%0d busy=%b done=%b vld=%b step=%0d err=%0d to=%b, want all 0",
                     bus.noise_sel, bus.busy, bus.done, bus.res_valid, bus.res_step, bus.res_err, bus.res_timeout);
        else n_pass++;
        rst_n = 1'b1;
        idle(3, 1'b0);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        else n_pass++;
    endtask

    task automatic test_clean_sweep();
        for (int s = 0; s < NS; s++) push_exp(s, 0, 1'b0);
        pulse_start();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.noise_sel !== 4'd0)
            $display("FAIL start_busy: busy=%b sel=%0d, want 1 0", bus.busy, bus.noise_sel);
        else n_pass++;
        for (int s = 0; s < NS; s++) clean_step();
        idle(2, 1'b0);
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.noise_sel !== 4'(NS - 1))
            $display("FAIL sweep_done: done=%b busy=%b sel=%0d, want 1 0 %0d",
                     bus.done, bus.busy, bus.noise_sel, NS - 1);
        else n_pass++;
    endtask

    task automatic test_error_count();
        push_exp(0, 0, 1'b0);
        push_exp(1, 5, 1'b0);
        push_exp(2, 0, 1'b0);
        pulse_start();
        clean_step();
        idle(12, 1'b1);
        step_frames(FPS, 4, 1'b1, 1'b1);
        clean_step();
        idle(2, 1'b0);
    endtask

    task automatic test_timeout();
        int seen = 0;
        push_exp(0, 0, 1'b1);
        push_exp(1, 0, 1'b0);
        push_exp(2, 0, 1'b0);
        bus.sync_lock = 1'b0;
        pulse_start();
        for (int k = 1; k <= 80; k++) begin
            cyc((k % 20) == 3, 1'b0);
            if (bus.res_valid === 1'b1) begin
                seen = k;
                break;
            end
        end
        n_checks++;
        if (seen != SC + ST)
            $display("FAIL timeout_latency: res_valid at cycle %0d after start, want %0d", seen, SC + ST);
        else n_pass++;
        bus.sync_lock = 1'b1;
        idle(5, 1'b0);
        n_checks++;
        if (bus.res_timeout !== 1'b1)
            $display("FAIL timeout_hold: res_timeout=%b after report, want 1", bus.res_timeout);
        else n_pass++;
        idle(7, 1'b0);
        step_frames(FPS, 0, 1'b0, 1'b0);
        n_checks++;
        if (bus.res_timeout !== 1'b0)
            $display("FAIL timeout_clear: res_timeout=%b on locked step, want 0", bus.res_timeout);
        else n_pass++;
        clean_step();
        idle(2, 1'b0);
    endtask

    task automatic test_sync_loss();
        push_exp(0, 1, 1'b0);
        push_exp(1, 0, 1'b0);
        push_exp(2, 0, 1'b0);
        pulse_start();
        idle(12, 1'b0);
        cyc(1'b1, 1'b0);
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 19; c++) cyc(1'b0, (f == 0) && (c < 3));
            cyc(1'b1, 1'b0);
        end
        bus.sync_lock = 1'b0;
        idle(4, 1'b0);
        bus.sync_lock = 1'b1;
        idle(2, 1'b0);
        step_frames(FPS, 0, 1'b1, 1'b0);
        // step 1: lock drops on the very cycle of the final frame_tick
        idle(12, 1'b0);
        cyc(1'b1, 1'b0);
        for (int f = 0; f < FPS - 1; f++) begin
            idle(19, 1'b0);
            cyc(1'b1, 1'b0);
        end
        idle(19, 1'b0);
        bus.sync_lock = 1'b0;
        cyc(1'b1, 1'b1);
        bus.sync_lock = 1'b1;
        n_checks++;
        if (bus.res_valid !== 1'b0)
            $display("FAIL sync_loss_priority: res_valid=%b on lost final tick, want 0", bus.res_valid);
        else n_pass++;
        idle(3, 1'b0);
        step_frames(FPS, 0, 1'b0, 1'b0);
        clean_step();
        idle(2, 1'b0);
    endtask

    task automatic test_saturation();
        push_exp(0, 10, 1'b0);
        push_exp(1, 0, 1'b0);
        push_exp(2, 0, 1'b0);
        pulse_start();
        idle(12, 1'b0);
        step_frames(FPS, 10, 1'b0, 1'b0);
        clean_step();
        clean_step();
        idle(2, 1'b0);
    endtask

    task automatic test_abort();
        push_exp(0, 0, 1'b0);
        pulse_start();
        clean_step();
        idle(12, 1'b0);
        cyc(1'b1, 1'b0);
        idle(19, 1'b0);
        cyc(1'b1, 1'b1);
        idle(5, 1'b1);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk_fs);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.noise_sel !== 4'd0)
            $display("FAIL abort_state: busy=%b done=%b sel=%0d, want 0 0 0", bus.busy, bus.done, bus.noise_sel);
        else n_pass++;
        idle(70, 1'b0);
        n_checks++;
        if (bus.busy !== 1'b0)
            $display("FAIL abort_start_ignored: busy=%b, want 0", bus.busy);
        else n_pass++;
        for (int s = 0; s < NS; s++) push_exp(s, 0, 1'b0);
        pulse_start();
        clean_step();
        idle(3, 1'b0);
        pulse_start();
        n_checks++;
        if (bus.noise_sel !== 4'd1 || bus.busy !== 1'b1)
            $display("FAIL start_while_busy: sel=%0d busy=%b, want 1 1", bus.noise_sel, bus.busy);
        else n_pass++;
        idle(8, 1'b0);
        step_frames(FPS, 0, 1'b0, 1'b0);
        clean_step();
        idle(2, 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        push_exp(0, 2, 1'b0);
        pulse_start();
        idle(12, 1'b0);
        step_frames(FPS, 2, 1'b0, 1'b0);
        idle(12, 1'b0);
        cyc(1'b1, 1'b0);
        idle(10, 1'b1);
        #20;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.noise_sel, bus.busy, bus.res_err, bus.res_step} !== '0)
            $display("FAIL async_reset: sel=%0d busy=%b err=%0d step=%0d, want all 0",
                     bus.noise_sel, bus.busy, bus.res_err, bus.res_step);
        else n_pass++;
        @(negedge clk_fs);
        rst_n = 1'b1;
        idle(80, 1'b0);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL after_reset_idle: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        else n_pass++;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.sync_lock  = 1'b1;
        bus.frame_tick = 1'b0;
        bus.bit_err    = 1'b0;
        @(negedge clk_fs);
        test_reset();
        test_clean_sweep();
        test_error_count();
        test_timeout();
        test_sync_loss();
        test_saturation();
        test_abort();
        test_reset_mid_sweep();
        n_checks++;
        if (exp_q.size() != 0 || exp_s.size() != 0)
            $display("FAIL missing_results: %0d/%0d expected results never reported, want 0",
                     exp_q.size(), exp_s.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(100 * 40000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
